// File: rtl/mmio_fifo_pkg.sv
// Shared types and constants for the MMIO write FIFO and its AFU decode.
// Provides payload type, CSR addresses and the status word packer.
package mmio_fifo_pkg;

    localparam int unsigned MMIO_FIFO_DATA_W = 64;

    typedef logic [63:0] t_mmio_fifo_data;

    localparam logic [15:0] MMIO_FIFO_ADDR_DATA   = 16'h0022;
    localparam logic [15:0] MMIO_FIFO_ADDR_STATUS = 16'h0024;

    // Status word: {overflow, underflow, full, empty, count[15:0]}
    // in the low bits, zero-extended to the 64-bit MMIO read width.
    function automatic t_mmio_fifo_data mmio_fifo_status(
        input logic        overflow,
        input logic        underflow,
        input logic        full,
        input logic        empty,
        input logic [15:0] count
    );
        t_mmio_fifo_data w;
        w = '0;
        w[19:0] = {overflow, underflow, full, empty, count};
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
// Ports: clk, rst_n, we/waddr/wdata, re/raddr, rdata (holds when re=0).
module mmio_fifo_ram
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = MMIO_FIFO_DATA_W,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array has no reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read samples the pre-write contents, giving read-first on
    // a same-address push and pop.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mmio_wr_fifo.sv
// Circular FIFO for MMIO write payloads, popped by MMIO reads.
// Ports: clk, rst_n, wr_en/wr_data, rd_en/rd_data/rd_valid, full, empty,
// count, sticky overflow/underflow, clr_err; almost_full when
// MMIO_WR_FIFO_ALMOST_FULL_EN is defined.
module mmio_wr_fifo
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = MMIO_FIFO_DATA_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
`ifdef MMIO_WR_FIFO_ALMOST_FULL_EN
    output logic                       almost_full,
`endif
    input  logic                       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_wr_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok  = rd_en & ~empty_q;
        // A pop frees a slot in the same cycle, so a full FIFO
        // still accepts a push paired with a pop.
        push_ok = wr_en & (~full_q | pop_ok);

        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop_ok);
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d     = (count_d == DEPTH_C);
        empty_d    = (count_d == '0);
        rd_valid_d = pop_ok;

        // An error event in the clearing cycle keeps its flag set.
        ovf_d = (ovf_q & ~clr_err) | (wr_en & ~push_ok);
        unf_d = (unf_q & ~clr_err) | (rd_en & empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    mmio_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef MMIO_WR_FIFO_ALMOST_FULL_EN
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("mmio_wr_fifo: AF_THRESH must be in 1..DEPTH");
    end

    localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

    logic af_q, af_d;

    always_comb begin
        af_d = (count_d >= AF_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full = af_q;
`endif

    assign rd_valid  = rd_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/mmio_wr_fifo.md
Name: mmio_wr_fifo

Overview:
- Circular-buffer FIFO that captures 64-bit MMIO write payloads decoded by the AFU MMIO block.
- Returns them in order on MMIO read requests.
- Sits directly downstream of the CCI-P MMIO decode: the AFU drives wr_en/wr_data from rx.c0 writes and rd_en from rx.c0 reads, and places rd_data into tx.c2.data.
- Adds full/empty flags, occupancy count and sticky error flags for host polling.

Parameters:
- DATA_W, 64, payload width in bits.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- AF_THRESH, 6, almost-full threshold in entries; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  push request, one cycle per entry.
- wr_data  in  DATA_W  push payload.
- rd_en  in  1  pop request, one cycle per entry.
- rd_data  out  DATA_W  popped payload, registered.
- rd_valid  out  1  one-cycle pulse: rd_data was updated by an accepted pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was attempted while full and not accepted.
- underflow  out  1  sticky: a pop was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, sync release by integrator):
  - pointers = 0, count = 0, empty = 1, full = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Storage contents are don't-care.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held separately so full and empty are unambiguous.
  - full, empty and count are registered, derived from the next-state count.
- Push accept: push_ok = wr_en & (~full | pop_ok).
  - Entry is written at wr_ptr; wr_ptr increments.
- Pop accept: pop_ok = rd_en & ~empty.
  - rd_data <= mem[rd_ptr] on the next edge; rd_ptr increments; rd_valid = 1 for that cycle.
  - Latency from rd_en to rd_data/rd_valid is 1 cycle.
- Rejected pop:
  - rd_data holds its previous value and rd_valid = 0.
  - underflow sets on the next edge.
- Rejected push:
  - The entry is dropped and pointers are unchanged.
  - overflow sets on the next edge.
- Simultaneous push and pop:
  - Full: both accepted (read-first); count unchanged; the popped entry is the oldest.
  - Empty: push accepted, pop rejected (no bypass); underflow sets; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count update: count_next = count + push_ok - pop_ok. It never exceeds DEPTH or goes below 0.
- clr_err:
  - Clears both sticky flags.
  - If an error event occurs in the same cycle, the event wins and the flag stays/becomes 1.
- Reset asserted mid-operation: all state returns to reset values immediately; queued data is lost.

Optional Feature:
- Macro: MMIO_WR_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output port almost_full (1 bit), registered, = (count_next >= AF_THRESH).
  - Reset value 0.
  - AF_THRESH must be in 1..DEPTH; checked with an elaboration-time assertion.
- Undefined: the port, its logic and the AF_THRESH check are absent; all other behaviour is identical.

Decomposition:
- Package mmio_fifo_pkg:
  - MMIO_FIFO_DATA_W = 64.
  - Typedef t_mmio_fifo_data (logic [63:0]).
  - MMIO CSR address constants for the AFU decode: 16'h0022 push/pop data, 16'h0024 status.
  - Status word packing function: {overflow, underflow, full, empty, count} in low bits, zero-extended to 64.
- Sub-module mmio_fifo_ram:
  - DEPTH x DATA_W storage with one write port and one registered read port.
  - No reset on the array.
  - The top owns pointers, count, flags and handshake.

Test Plan:
- Reset then push 3 words 0x11, 0x22, 0x33 -> count = 3, empty = 0. Pop 3 -> rd_data 0x11, 0x22, 0x33, each one cycle after rd_en with rd_valid pulsed; final empty = 1, count = 0.
- Fill 8 entries 0x0..0x7, then push 0xAA -> full = 1, count = 8, overflow = 1. Drain 8 -> 0x0..0x7 with 0xAA absent.
- When full, push 0xBB and pop in the same cycle -> rd_data = 0x0, count stays 8, overflow stays 0. Later pops yield 0x1..0x7 then 0xBB.
- When empty, push 0xCC and pop in the same cycle -> rd_valid = 0, underflow = 1, count = 1. Next pop -> rd_data = 0xCC.
- Run 20 push/pop pairs across pointer wrap (DEPTH = 8) with an incrementing pattern -> output order equals input order. Pulse clr_err -> both flags clear. Pulse clr_err together with a pop on empty -> underflow remains 1.
- Push 4 entries, assert rst_n = 0 asynchronously mid-cycle -> count = 0, empty = 1, rd_data = 0 immediately. With MMIO_WR_FIFO_ALMOST_FULL_EN and AF_THRESH = 6 -> almost_full rises on the 6th push and falls after the 1st pop at count 6.
